drf_pattern_player: RTL and testbench
=====================================

// Module: drf_pattern_player
// PURPOSE
//  Sequenced stimulus source for the 4-bit DRF input port. Plays a stored list of
//  (symbol, hold) entries onto pattern_out, e.g. 0010 for 150 cycles, then 0000.
//  Samples the DRF port_output at the last cycle of each entry for checking.
//  Sits in front of drf_system: pattern_out -> port_input, port_output -> resp_in.
// PARAMETERS
//  DEPTH        16   number of sequence entries (power of 2); ADDR_W = clog2(DEPTH)
//  HOLD_W       16   width of per-entry hold count, in clk cycles
//  IDLE_SYMBOL  4'b0000  value on pattern_out when not playing
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  wr_en        in   1       write entry wr_addr; ignored while busy
//  wr_addr      in   ADDR_W  entry index
//  wr_symbol    in   4       symbol to drive
//  wr_hold      in   HOLD_W  cycles to hold; 0 treated as 1
//  seq_len      in   ADDR_W+1 entries to play (0..DEPTH); sampled on accepted start
//  start        in   1       begin playback; ignored while busy
//  loop         in   1       sampled on accepted start; 1 = wrap to entry 0 forever
//  abort        in   1       stop playback; wins over all other events
//  resp_in      in   4       DRF port_output
//  pattern_out  out  4       registered symbol to DRF port_input
//  busy         out  1       high in PLAY
//  done         out  1       1-cycle pulse at normal end of non-loop playback
//  step_idx     out  ADDR_W  entry currently driven
//  resp_sample  out  4       resp_in captured at last cycle of current entry
//  resp_valid   out  1       1-cycle pulse, resp_sample updated
// BEHAVIOUR
//  Reset: pattern_out=IDLE_SYMBOL, busy=0, done=0, step_idx=0, resp_sample=0,
//   resp_valid=0, state=IDLE. Entry memory is not cleared.
//  FSM: IDLE -> PLAY -> (IDLE, done pulse). Abort or reset in any state -> IDLE.
//  IDLE: start=1 and seq_len>0: next cycle pattern_out=mem[0].symbol, busy=1,
//   step_idx=0, hold counter loaded max(mem[0].hold,1). Latency start->symbol = 1 clk.
//  start=1 and seq_len=0: no playback; done pulses next cycle; busy stays 0.
//  PLAY: each entry drives its symbol for exactly max(hold,1) consecutive cycles.
//   On the final cycle of an entry, resp_in is registered -> resp_sample,
//   resp_valid=1 the next cycle.
//   Next entry symbol appears the cycle after the final cycle; no idle gap.
//  End of last entry (step_idx = seq_len-1):
//   loop=0: next cycle pattern_out=IDLE_SYMBOL, busy=0, done=1 for one cycle, step_idx=0.
//   loop=1: wrap to entry 0 with no gap; done never pulses.
//  abort=1: next cycle IDLE, pattern_out=IDLE_SYMBOL, busy=0, no done, no resp_valid
//   for the truncated entry. abort with start in the same cycle: abort wins.
//  wr_en while busy: dropped. wr_en and start in the same IDLE cycle: write
//   commits first, so entry 0 of the playback uses the new data.
//  seq_len > DEPTH: clamped to DEPTH.
//  Hold counter: HOLD_W bits, counts down to 1; no wrap.
// STRUCTURE
//  Shared package drf_pkg: SYM_W=4, IDLE_SYMBOL, FSM state encoding
//   (ST_IDLE, ST_PLAY), entry struct {symbol, hold}.
//  Sub-module drf_pattern_mem: DEPTH x (4+HOLD_W) register file, 1 write port,
//   1 async read port. Player FSM, counters and response capture live in the top.
// TESTING
//  1 Reset, then idle 10 cycles -> pattern_out=0000, busy=0, done=0, resp_valid=0.
//  2 Load {0010,150},{0000,150}; start, len=2 -> 0010 for exactly 150 cycles, then
//    0000 for 150; done 1 pulse at cycle 301; 2 resp_valid pulses.
//  3 Load {0010,3},{0100,0}, loop=1, len=2 -> 0010,0010,0010,0100 repeating;
//    done never pulses; abort at cycle 9 -> 0000 at cycle 10, busy=0.
//  4 start with len=0 -> done pulse next cycle, busy=0, pattern_out=0000.
//  5 wr_en during PLAY to entry 1 -> entry 1 plays old data. Start+abort same
//    cycle -> no playback.
//  6 Reset asserted mid-entry -> next cycle all outputs at reset values. Loop back
//    resp_in=pattern_out -> resp_sample equals each entry's symbol.

Source files
------------

// File: rtl/drf_pkg.sv
// rtl/drf_pkg.sv - shared types and constants for the DRF pattern player
package drf_pkg;

  localparam int SYM_W      = 4;
  localparam int DEF_HOLD_W = 16;

  localparam logic [SYM_W-1:0] IDLE_SYMBOL = 4'b0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  typedef struct packed {
    logic [SYM_W-1:0]      symbol;
    logic [DEF_HOLD_W-1:0] hold;
  } entry_t;

endpackage

// File: rtl/drf_pattern_mem.sv
// rtl/drf_pattern_mem.sv - sequence entry register file, 1 write port, 1 async read port
//   clk                          write clock
//   wr_en/wr_addr/wr_symbol/wr_hold   write port
//   rd_addr -> rd_symbol/rd_hold      combinational read port
module drf_pattern_mem
  import drf_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int HOLD_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_symbol,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SYM_W-1:0]  rd_symbol,
  output logic [HOLD_W-1:0] rd_hold
);

  logic [SYM_W-1:0]  sym_mem  [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];

  // Contents survive reset on purpose: a loaded sequence can be replayed after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sym_mem[wr_addr]  <= wr_symbol;
      hold_mem[wr_addr] <= wr_hold;
    end
  end

  assign rd_symbol = sym_mem[rd_addr];
  assign rd_hold   = hold_mem[rd_addr];

endmodule

// File: rtl/drf_pattern_player.sv
// rtl/drf_pattern_player.sv - plays stored (symbol, hold) entries onto the DRF input port
//   clk, reset                        clock, synchronous active-high reset
//   wr_en/wr_addr/wr_symbol/wr_hold   entry load port (ignored while busy)
//   seq_len, start, loop, abort       playback control
//   resp_in                           DRF port_output
//   pattern_out, busy, done, step_idx playback status
//   resp_sample, resp_valid           response captured at the last cycle of each entry
module drf_pattern_player
  import drf_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int HOLD_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_symbol,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic [ADDR_W:0]   seq_len,
  input  logic              start,
  input  logic              loop,
  input  logic              abort,
  input  logic [SYM_W-1:0]  resp_in,
  output logic [SYM_W-1:0]  pattern_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_idx,
  output logic [SYM_W-1:0]  resp_sample,
  output logic              resp_valid
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] STEP_ONE = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t              state_q, state_d;
  logic [SYM_W-1:0]    pat_q, pat_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                loop_q, loop_d;
  logic                done_q, done_d;
  logic                rv_q, rv_d;
  logic [SYM_W-1:0]    rs_q, rs_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SYM_W-1:0]    rd_symbol, ent_symbol;
  logic [HOLD_W-1:0]   rd_hold, ent_hold, ld_hold;
  logic [ADDR_W:0]     len_clamp;
  logic                last_entry;
  logic                entry_end;
  logic [ADDR_W-1:0]   next_idx;

  assign mem_we = wr_en && (state_q == ST_IDLE);

  drf_pattern_mem #(
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) u_mem (
    .clk       (clk),
    .wr_en     (mem_we),
    .wr_addr   (wr_addr),
    .wr_symbol (wr_symbol),
    .wr_hold   (wr_hold),
    .rd_addr   (rd_addr),
    .rd_symbol (rd_symbol),
    .rd_hold   (rd_hold)
  );

  // A write landing in the same cycle as start must be seen by entry 0, so the
  // read path forwards the write data when the addresses match.
  assign ent_symbol = (mem_we && wr_addr == rd_addr) ? wr_symbol : rd_symbol;
  assign ent_hold   = (mem_we && wr_addr == rd_addr) ? wr_hold   : rd_hold;
  assign ld_hold    = (ent_hold == '0) ? HOLD_ONE : ent_hold;

  assign len_clamp  = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
  assign last_entry = ({1'b0, step_q} == (len_q - LEN_ONE));
  assign entry_end  = (hold_q <= HOLD_ONE);
  assign next_idx   = last_entry ? '0 : (step_q + STEP_ONE);
  assign rd_addr    = (state_q == ST_PLAY) ? next_idx : '0;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    step_d  = step_q;
    hold_d  = hold_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    rv_d    = 1'b0;
    rs_d    = rs_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!abort && start) begin
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_PLAY;
            pat_d   = ent_symbol;
            step_d  = '0;
            hold_d  = ld_hold;
            len_d   = len_clamp;
            loop_d  = loop;
          end
        end
      end

      ST_PLAY: begin
        if (abort) begin
          state_d = ST_IDLE;
          pat_d   = IDLE_SYMBOL;
          step_d  = '0;
        end else if (entry_end) begin
          rs_d = resp_in;
          rv_d = 1'b1;
          if (last_entry && !loop_q) begin
            state_d = ST_IDLE;
            pat_d   = IDLE_SYMBOL;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            pat_d  = ent_symbol;
            step_d = next_idx;
            hold_d = ld_hold;
          end
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pat_d   = IDLE_SYMBOL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= IDLE_SYMBOL;
      step_q  <= '0;
      hold_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rs_q    <= rs_d;
    end
  end

  assign pattern_out = pat_q;
  assign busy        = (state_q == ST_PLAY);
  assign done        = done_q;
  assign step_idx    = step_q;
  assign resp_sample = rs_q;
  assign resp_valid  = rv_q;

endmodule

// File: tb/tb_drf_pattern_player.sv
// tb/tb_drf_pattern_player.sv - directed self-checking bench for drf_pattern_player
module tb_drf_pattern_player;

  localparam int DEPTH  = 16;
  localparam int HOLD_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_symbol;
  logic [HOLD_W-1:0] wr_hold;
  logic [ADDR_W:0]   seq_len;
  logic              start;
  logic              loop;
  logic              abort;
  logic [3:0]        resp_in;
  logic [3:0]        pattern_out;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_idx;
  logic [3:0]        resp_sample;
  logic              resp_valid;

  logic              loopback;
  logic [3:0]        resp_drv;

  assign resp_in = loopback ? pattern_out : resp_drv;

  drf_pattern_player #(
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_symbol   (wr_symbol),
    .wr_hold     (wr_hold),
    .seq_len     (seq_len),
    .start       (start),
    .loop        (loop),
    .abort       (abort),
    .resp_in     (resp_in),
    .pattern_out (pattern_out),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx),
    .resp_sample (resp_sample),
    .resp_valid  (resp_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int s, input int h);
    wr_en     = 1'b1;
    wr_addr   = a[ADDR_W-1:0];
    wr_symbol = s[3:0];
    wr_hold   = h[HOLD_W-1:0];
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    int rvn;
    int dn;
    logic [3:0] exp_sym;
    logic [3:0] exp_step;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_symbol = '0; wr_hold = '0;
    seq_len = '0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    loopback = 1'b0; resp_drv = 4'h0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    repeat (10) tick();
    chk("idle_pattern", pattern_out, 4'b0000);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_resp_valid", resp_valid, 1'b0);
    chk("idle_step", step_idx, 4'd0);
    chk("idle_resp_sample", resp_sample, 4'd0);

    // Two long entries, one-shot: 0010 x150 then 0000 x150, done at cycle 301
    wr(0, 4'b0010, 150);
    wr(1, 4'b0000, 150);
    resp_drv = 4'h9;
    seq_len = 5'd2; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    errs = 0; rvn = 0; dn = 0;
    for (int c = 1; c <= 300; c++) begin
      exp_sym = (c <= 150) ? 4'b0010 : 4'b0000;
      if (pattern_out !== exp_sym) errs++;
      if (busy !== 1'b1) errs++;
      if (resp_valid === 1'b1) rvn++;
      if (done === 1'b1) dn++;
      tick();
    end
    chk("long_pattern_errs", errs, 0);
    chk("long_early_done", dn, 0);
    chk("long_rv_before_end", rvn, 1);
    chk("long_done_301", done, 1'b1);
    chk("long_rv_301", resp_valid, 1'b1);
    chk("long_busy_301", busy, 1'b0);
    chk("long_pattern_301", pattern_out, 4'b0000);
    chk("long_resp_sample", resp_sample, 4'h9);
    tick();
    chk("long_done_302", done, 1'b0);

    // Looping with a zero hold entry, aborted at cycle 9
    wr(0, 4'b0010, 3);
    wr(1, 4'b0100, 0);
    seq_len = 5'd2; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    errs = 0; rvn = 0; dn = 0;
    for (int c = 1; c <= 9; c++) begin
      exp_sym  = ((c - 1) % 4 == 3) ? 4'b0100 : 4'b0010;
      exp_step = ((c - 1) % 4 == 3) ? 4'd1 : 4'd0;
      if (pattern_out !== exp_sym) errs++;
      if (step_idx !== exp_step) errs++;
      if (resp_valid === 1'b1) rvn++;
      if (done === 1'b1) dn++;
      if (c == 9) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk("loop_pattern_errs", errs, 0);
    chk("loop_done_never", dn, 0);
    chk("loop_rv_count", rvn, 4);
    chk("abort_pattern", pattern_out, 4'b0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rv", resp_valid, 1'b0);

    // Zero-length start
    seq_len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_pattern", pattern_out, 4'b0000);
    tick();
    chk("len0_done_clear", done, 1'b0);

    // Write during playback is dropped
    wr(0, 4'b0001, 5);
    wr(1, 4'b0011, 2);
    seq_len = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr(1, 4'b0111, 9);
    tick();
    tick();
    chk("wrbusy_c5", pattern_out, 4'b0001);
    tick();
    chk("wrbusy_c6", pattern_out, 4'b0011);
    tick();
    chk("wrbusy_c7", pattern_out, 4'b0011);
    tick();
    chk("wrbusy_c8_pattern", pattern_out, 4'b0000);
    chk("wrbusy_c8_done", done, 1'b1);

    // Write and start in the same cycle: entry 0 uses the new data
    wr_en = 1'b1; wr_addr = 4'd0; wr_symbol = 4'hA; wr_hold = 16'd1;
    seq_len = 5'd1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("wrstart_pattern", pattern_out, 4'hA);
    chk("wrstart_busy", busy, 1'b1);
    tick();
    chk("wrstart_done", done, 1'b1);

    // Start and abort together: abort wins
    seq_len = 5'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", busy, 1'b0);
    chk("startabort_pattern", pattern_out, 4'b0000);
    tick();
    chk("startabort_done", done, 1'b0);

    // Full depth with oversize seq_len clamped to 16, response looped back
    for (int i = 0; i < DEPTH; i++) wr(i, i, 1);
    loopback = 1'b1;
    seq_len = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    errs = 0;
    for (int c = 1; c <= 16; c++) begin
      exp_sym = 4'(c - 1);
      if (pattern_out !== exp_sym) errs++;
      if (busy !== 1'b1) errs++;
      if (c >= 2) begin
        exp_sym = 4'(c - 2);
        if (resp_valid !== 1'b1) errs++;
        if (resp_sample !== exp_sym) errs++;
      end
      tick();
    end
    chk("clamp_loopback_errs", errs, 0);
    chk("clamp_done_17", done, 1'b1);
    chk("clamp_resp_sample_17", resp_sample, 4'd15);
    chk("clamp_pattern_17", pattern_out, 4'b0000);
    loopback = 1'b0;

    // Reset mid-entry
    wr(0, 4'b0101, 10);
    seq_len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midreset_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_pattern", pattern_out, 4'b0000);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_step", step_idx, 4'd0);
    chk("midreset_resp_sample", resp_sample, 4'd0);
    chk("midreset_rv", resp_valid, 1'b0);
    chk("midreset_done", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
